// File: rtl/hamming_decoder.sv
// Hamming(7,4) single-error-correcting decoder with a 2-stage pipeline,
// saturating corrected-word counter and sticky burst-alarm quality FSM.
module hamming_decoder #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ALARM_THRESH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [6:0]       hamming_code,
  input  logic             clear,
  output logic [3:0]       bin_nat,
  output logic             out_valid,
  output logic [2:0]       syndrome,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_count,
  output logic             alarm,
  output logic [1:0]       q_state
);

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;
  localparam int unsigned RUN_W  = 4;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_ALARM    = 2'd2
  } state_t;

  logic              v1;
  logic [CODE_W-1:0] cw1;
  logic [SYN_W-1:0]  syn1;
  logic [SYN_W-1:0]  syn_in;
  logic [CODE_W-1:0] cw_fix;
  logic [DATA_W-1:0] data_fix;

  state_t            state;
  state_t            state_nxt;
  logic [RUN_W-1:0]  run;
  logic [RUN_W-1:0]  run_nxt;

  // Syndrome bit k covers every position whose index has bit k set.
  assign syn_in = {^(hamming_code & 7'b1111000),
                   ^(hamming_code & 7'b1100110),
                   ^(hamming_code & 7'b1010101)};

  // Stage 1: capture codeword and syndrome.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1   <= 1'b0;
      cw1  <= '0;
      syn1 <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        cw1  <= hamming_code;
        syn1 <= syn_in;
      end
    end
  end

  // A nonzero syndrome names the 1-based position to flip.
  always_comb begin
    cw_fix = cw1;
    for (int i = 0; i < int'(CODE_W); i++) begin
      cw_fix[i] = cw1[i] ^ (syn1 == SYN_W'(i + 1));
    end
  end

  // Data positions 3,5,6,7 -> {d1,d2,d3,d4}.
  assign data_fix = {cw_fix[2], cw_fix[4], cw_fix[5], cw_fix[6]};

  // Stage 2: corrected data and status; outputs hold across bubbles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      bin_nat   <= '0;
      syndrome  <= '0;
      err_flag  <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        bin_nat  <= data_fix;
        syndrome <= syn1;
        err_flag <= (syn1 != '0);
      end
    end
  end

  // Saturating count of corrected words; clear beats a coincident error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (out_valid && err_flag && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_OK;
      run   <= '0;
      alarm <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
      alarm <= (state_nxt == ST_ALARM);
    end
  end

  // Quality FSM advances only on delivered words.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    if (clear) begin
      state_nxt = ST_OK;
      run_nxt   = '0;
    end else if (out_valid) begin
      case (state)
        ST_OK: begin
          if (err_flag) begin
            run_nxt   = RUN_W'(1);
            state_nxt = (ALARM_THRESH <= 1) ? ST_ALARM : ST_DEGRADED;
          end
        end
        ST_DEGRADED: begin
          if (err_flag) begin
            run_nxt = run + RUN_W'(1);
            if (run_nxt >= RUN_W'(ALARM_THRESH)) begin
              state_nxt = ST_ALARM;
            end
          end else begin
            state_nxt = ST_OK;
            run_nxt   = '0;
          end
        end
        ST_ALARM: begin
          state_nxt = ST_ALARM;
        end
        default: begin
          state_nxt = ST_OK;
          run_nxt   = '0;
        end
      endcase
    end
  end

  assign q_state = state;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: latency, correction, ordering,
// burst alarm, counter saturation/clear priority and async reset.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [6:0] hamming_code;
  logic       clear;

  logic [3:0] bin_nat;
  logic       out_valid;
  logic [2:0] syndrome;
  logic       err_flag;
  logic [7:0] err_count;
  logic       alarm;
  logic [1:0] q_state;

  logic [3:0] bin_nat2;
  logic       out_valid2;
  logic [2:0] syndrome2;
  logic       err_flag2;
  logic [1:0] err_count2;
  logic       alarm2;
  logic [1:0] q_state2;

  int vecs = 0;
  int errs = 0;

  localparam logic [6:0] CLEAN = 7'b1100110;
  localparam logic [6:0] ERRW  = 7'b1110110;

  always #5 clk = ~clk;

  hamming_decoder #(.CNT_W(8), .ALARM_THRESH(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .hamming_code(hamming_code),
    .clear(clear), .bin_nat(bin_nat), .out_valid(out_valid), .syndrome(syndrome),
    .err_flag(err_flag), .err_count(err_count), .alarm(alarm), .q_state(q_state)
  );

  hamming_decoder #(.CNT_W(2), .ALARM_THRESH(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .hamming_code(hamming_code),
    .clear(clear), .bin_nat(bin_nat2), .out_valid(out_valid2), .syndrome(syndrome2),
    .err_flag(err_flag2), .err_count(err_count2), .alarm(alarm2), .q_state(q_state2)
  );

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic d1, d2, d3, d4;
    d1 = d[3]; d2 = d[2]; d3 = d[1]; d4 = d[0];
    return {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send_word(input logic [6:0] c);
    in_valid = 1'b1;
    hamming_code = c;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; hamming_code = '0; clear = 1'b0;
    #12;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    vecs++; if (bin_nat !== 4'd0) begin errs++; $display("FAIL rst_bin_nat got %b exp 0000", bin_nat); end
    vecs++; if (syndrome !== 3'd0 || err_flag !== 1'b0) begin errs++; $display("FAIL rst_syn got %0d/%b exp 0/0", syndrome, err_flag); end
    vecs++; if (err_count !== 8'd0 || alarm !== 1'b0 || q_state !== 2'd0) begin errs++; $display("FAIL rst_status got %0d/%b/%0d exp 0/0/0", err_count, alarm, q_state); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_clean();
    in_valid = 1'b1; hamming_code = CLEAN;
    tick();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL clean_lat1 got out_valid %b exp 0", out_valid); end
    tick();
    vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL clean_lat2 got out_valid %b exp 1", out_valid); end
    vecs++; if (bin_nat !== 4'b1011) begin errs++; $display("FAIL clean_data got %b exp 1011", bin_nat); end
    vecs++; if (syndrome !== 3'd0 || err_flag !== 1'b0) begin errs++; $display("FAIL clean_syn got %0d/%b exp 0/0", syndrome, err_flag); end
    tick();
    vecs++; if (out_valid !== 1'b0 || bin_nat !== 4'b1011) begin errs++; $display("FAIL clean_hold got %b/%b exp 0/1011", out_valid, bin_nat); end
    vecs++; if (err_count !== 8'd0) begin errs++; $display("FAIL clean_cnt got %0d exp 0", err_count); end
  endtask

  task automatic test_error_sweep();
    logic [6:0] base;
    base = CLEAN;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        in_valid = 1'b1;
        hamming_code = base ^ (7'(1) << i);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        vecs++;
        if (out_valid !== 1'b1 || bin_nat !== 4'b1011 || syndrome !== 3'(i) || err_flag !== 1'b1) begin
          errs++;
          $display("FAIL sweep_bit%0d got v=%b d=%b s=%0d e=%b exp 1/1011/%0d/1", i - 1, out_valid, bin_nat, syndrome, err_flag, i);
        end
      end
    end
    tick();
    tick();
    vecs++; if (err_count !== 8'd7) begin errs++; $display("FAIL sweep_cnt got %0d exp 7", err_count); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) begin
        in_valid = 1'b1;
        hamming_code = enc(4'(i));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        vecs++;
        if (out_valid !== 1'b1 || bin_nat !== 4'(i - 1) || syndrome !== 3'd0) begin
          errs++;
          $display("FAIL b2b_word%0d got v=%b d=%b s=%0d exp 1/%b/0", i - 1, out_valid, bin_nat, syndrome, 4'(i - 1));
        end
      end
    end
    tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_tail got out_valid %b exp 0", out_valid); end
    vecs++; if (err_count !== 8'd0) begin errs++; $display("FAIL b2b_cnt got %0d exp 0", err_count); end
  endtask

  task automatic test_burst();
    logic [6:0] pat  [8];
    logic [1:0] expq [8];
    pat  = '{ERRW, ERRW, CLEAN, ERRW, ERRW, ERRW, CLEAN, CLEAN};
    expq = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    do_clear();
    for (int i = 0; i < 8; i++) begin
      send_word(pat[i]);
      vecs++;
      if (q_state !== expq[i] || alarm !== (expq[i] == 2'd2)) begin
        errs++;
        $display("FAIL burst_step%0d got q=%0d a=%b exp q=%0d a=%b", i, q_state, alarm, expq[i], expq[i] == 2'd2);
      end
      vecs++;
      if (q_state2 !== 2'd2 || alarm2 !== 1'b1) begin
        errs++;
        $display("FAIL burst_th1_step%0d got q=%0d a=%b exp q=2 a=1", i, q_state2, alarm2);
      end
    end
    do_clear();
    vecs++; if (q_state !== 2'd0 || alarm !== 1'b0 || err_count !== 8'd0) begin errs++; $display("FAIL burst_clear got q=%0d a=%b c=%0d exp 0/0/0", q_state, alarm, err_count); end
    vecs++; if (q_state2 !== 2'd0 || alarm2 !== 1'b0) begin errs++; $display("FAIL burst_clear_th1 got q=%0d a=%b exp 0/0", q_state2, alarm2); end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; hamming_code = ERRW;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    vecs++; if (err_count2 !== 2'd3) begin errs++; $display("FAIL sat_cnt2 got %0d exp 3", err_count2); end
    vecs++; if (err_count !== 8'd5) begin errs++; $display("FAIL sat_cnt8 got %0d exp 5", err_count); end
    in_valid = 1'b1; hamming_code = ERRW;
    tick();
    in_valid = 1'b0;
    tick();
    vecs++; if (out_valid !== 1'b1 || err_flag !== 1'b1) begin errs++; $display("FAIL prio_word got v=%b e=%b exp 1/1", out_valid, err_flag); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vecs++; if (err_count !== 8'd0 || err_count2 !== 2'd0) begin errs++; $display("FAIL prio_clear got %0d/%0d exp 0/0", err_count, err_count2); end
    tick();
    vecs++; if (err_count !== 8'd0 || q_state !== 2'd0) begin errs++; $display("FAIL prio_after got c=%0d q=%0d exp 0/0", err_count, q_state); end
  endtask

  task automatic test_async_reset();
    do_clear();
    send_word(ERRW);
    send_word(ERRW);
    vecs++; if (err_count !== 8'd2 || q_state !== 2'd1) begin errs++; $display("FAIL ar_pre got c=%0d q=%0d exp 2/1", err_count, q_state); end
    in_valid = 1'b1; hamming_code = 7'b1100111;
    tick();
    hamming_code = 7'b0100110;
    tick();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b1 || syndrome !== 3'd1) begin errs++; $display("FAIL ar_inflight got v=%b s=%0d exp 1/1", out_valid, syndrome); end
    #2;
    reset = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0 || bin_nat !== 4'd0) begin errs++; $display("FAIL ar_data got v=%b d=%b exp 0/0000", out_valid, bin_nat); end
    vecs++; if (syndrome !== 3'd0 || err_flag !== 1'b0) begin errs++; $display("FAIL ar_syn got %0d/%b exp 0/0", syndrome, err_flag); end
    vecs++; if (err_count !== 8'd0 || alarm !== 1'b0 || q_state !== 2'd0) begin errs++; $display("FAIL ar_status got %0d/%b/%0d exp 0/0/0", err_count, alarm, q_state); end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL ar_ghost%0d got out_valid %b exp 0", i, out_valid); end
    end
    in_valid = 1'b1; hamming_code = enc(4'b0110);
    tick();
    in_valid = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL ar_lat1 got out_valid %b exp 0", out_valid); end
    tick();
    vecs++; if (out_valid !== 1'b1 || bin_nat !== 4'b0110) begin errs++; $display("FAIL ar_lat2 got v=%b d=%b exp 1/0110", out_valid, bin_nat); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_error_sweep();
    test_back_to_back();
    test_burst();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hamming_decoder.md
Name: hamming_decoder

Overview:
Hamming(7,4) single-error-correcting decoder with a 2-stage pipeline. It sits directly downstream of the binary-to-Hamming encoder and consumes its 7-bit hamming_code. It recovers the 4-bit bin_nat word and reports syndrome and correction events. It also keeps a saturating error counter and a line-quality state machine that raises a sticky alarm on bursts of corrupted words.

Parameters:
CNT_W, 8, width of the saturating corrected-word counter
ALARM_THRESH, 3, consecutive corrected words that trigger ALARM (legal range 1..15)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  hamming_code is valid this cycle
hamming_code  input  7  codeword; bit[i] = Hamming position i+1
clear  input  1  synchronous clear of err_count and alarm/state
bin_nat  output  4  decoded, corrected data {d1,d2,d3,d4}, d1 = MSB
out_valid  output  1  bin_nat/syndrome/err_flag valid this cycle
syndrome  output  3  {s3,s2,s1}; nonzero value = corrected bit position
err_flag  output  1  1 = a bit was corrected in this word
err_count  output  CNT_W  corrected words since reset/clear, saturating
alarm  output  1  sticky burst alarm
q_state  output  2  quality FSM state: 0 OK, 1 DEGRADED, 2 ALARM

Behaviour:
- Code layout, even parity. Positions 1..7 = p1,p2,d1,p3,d2,d3,d4.
  - p1 = d1^d2^d4; p2 = d1^d3^d4; p3 = d2^d3^d4.
- Syndrome:
  - s1 = xor(pos 1,3,5,7).
  - s2 = xor(pos 2,3,6,7).
  - s3 = xor(pos 4,5,6,7).
- Stage 1, on the in_valid edge: register the codeword, the computed syndrome and valid.
- Stage 2: flip the codeword bit at position = syndrome if syndrome != 0. Register the data bits, syndrome, err_flag = (syndrome != 0) and out_valid.
- Latency: exactly 2 clk from in_valid to out_valid.
- Throughput: 1 word/cycle. No backpressure.
- Bubbles (in_valid = 0) propagate as out_valid = 0.
- While out_valid = 0: bin_nat, syndrome and err_flag hold their last value.
- Double-bit errors are not detected. They are miscorrected as single errors; this is by design.
- err_count increments by 1 on each out_valid with err_flag = 1. It saturates at 2^CNT_W-1 with no wrap.
- Quality FSM advances only on out_valid cycles:
  - OK, error word -> DEGRADED, consecutive counter (run) = 1.
  - DEGRADED, error word -> run+1. When run reaches ALARM_THRESH -> ALARM.
  - DEGRADED, clean word -> OK, run = 0.
  - ALARM is sticky. It is left only by clear or reset, both of which return to OK.
  - If ALARM_THRESH = 1: OK, error word -> ALARM directly.
- alarm = (q_state == ALARM), registered.
- clear: synchronous, 1 cycle.
  - Sets err_count = 0, run = 0, q_state = OK.
  - Clear wins over a simultaneous error word, which is not counted.
  - Clear does not flush the pipeline.
- Reset values (reset = 0, immediate, asynchronous):
  - Pipeline valids = 0, so out_valid = 0.
  - bin_nat = 0, syndrome = 0, err_flag = 0, err_count = 0, alarm = 0, q_state = OK, run = 0.
- Reset mid-stream: in-flight words are discarded. The first out_valid after release comes 2 clk after the first in_valid sampled with reset = 1.

Test Plan:
- Clean word: hamming_code = 7'b1100110 (bin_nat 1011), in_valid 1 cycle -> 2 clk later out_valid = 1, bin_nat = 4'b1011, syndrome = 0, err_flag = 0, err_count = 0.
- Single-bit error sweep: flip each bit i of 7'b1100110 (e.g. 7'b1110110) -> bin_nat = 1011, syndrome = i+1 (5 for 1110110), err_flag = 1. After 7 words err_count = 7.
- Exhaustive round trip: all 16 bin_nat values encoded, back-to-back in_valid -> 16 consecutive out_valid cycles, each output equal to its input, in order, no gaps.
- Burst alarm: 2 error words, then a clean word, then 3 error words -> q_state 1, 1, 0, then alarm = 1 on the 3rd consecutive error. Alarm stays 1 after later clean words. clear -> q_state = 0, alarm = 0, err_count = 0.
- Saturation/clear priority: CNT_W = 2, 5 error words -> err_count stops at 3. clear asserted in the same cycle as an error out_valid -> err_count = 0 the next cycle.
- Async reset: drop reset between clock edges with 2 words in flight -> all outputs reset immediately. No out_valid appears for the dropped words after release.
